// File: rtl/frame_preproc_stream_pkg.sv
// Shared definitions for the streaming grayscale preprocessor: default weights,
// channel width, decimation pair states and the rounding-offset helper.
package preproc_pkg;

    localparam int CH_W_DEF      = 8;
    localparam int COEF_R_DEF    = 77;
    localparam int COEF_G_DEF    = 150;
    localparam int COEF_B_DEF    = 29;
    localparam int COEF_FRAC_DEF = 8;
    localparam int LINE_W_DEF    = 640;

    typedef enum logic {
        PAIR_IDLE = 1'b0,
        PAIR_HOLD = 1'b1
    } pair_state_t;

    // Half an LSB of the fixed-point weights, added before the right shift.
    function automatic int round_offset(input int frac);
        return 1 << (frac - 1);
    endfunction

endpackage

// File: rtl/frame_preproc_stream_if.sv
// Pixel stream bundle: data, valid/ready handshake and frame/line sideband.
interface frame_preproc_stream_if #(
    parameter int DATA_W = 24
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sof;
    logic              eol;

    modport master (output data, output valid, output sof, output eol, input ready);
    modport slave  (input data, input valid, input sof, input eol, output ready);

endinterface

// File: rtl/frame_preproc_stream_rgb2gray.sv
// Two-stage weighted RGB->gray datapath (products, then rounded sum) with an
// enable that freezes both stages, plus a sideband that travels alongside.
module rgb2gray_pipe
    import preproc_pkg::*;
#(
    parameter int CH_W      = CH_W_DEF,
    parameter int COEF_R    = COEF_R_DEF,
    parameter int COEF_G    = COEF_G_DEF,
    parameter int COEF_B    = COEF_B_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int SB_W      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic [3*CH_W-1:0]   i_rgb,
    input  logic [SB_W-1:0]     i_sb,
    output logic                o_valid,
    output logic [CH_W+2:0]     o_gray,
    output logic [SB_W-1:0]     o_sb
);

    localparam int P_W = CH_W + COEF_FRAC + 1;
    localparam int S_W = CH_W + COEF_FRAC + 3;
    localparam logic [S_W-1:0] RND = S_W'(round_offset(COEF_FRAC));

    logic [P_W-1:0]  w_pr, w_pg, w_pb;
    logic [S_W-1:0]  w_sum;

    logic            r_v1;
    logic [P_W-1:0]  r_pr, r_pg, r_pb;
    logic [SB_W-1:0] r_sb1;
    logic            r_v2;
    logic [CH_W+2:0] r_gray;
    logic [SB_W-1:0] r_sb2;

    assign w_pr  = P_W'(i_rgb[3*CH_W-1:2*CH_W]) * P_W'(COEF_R);
    assign w_pg  = P_W'(i_rgb[2*CH_W-1:CH_W])   * P_W'(COEF_G);
    assign w_pb  = P_W'(i_rgb[CH_W-1:0])        * P_W'(COEF_B);
    assign w_sum = S_W'(r_pr) + S_W'(r_pg) + S_W'(r_pb) + RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_pr   <= '0;
            r_pg   <= '0;
            r_pb   <= '0;
            r_sb1  <= '0;
            r_v2   <= 1'b0;
            r_gray <= '0;
            r_sb2  <= '0;
        end else if (i_en) begin
            r_v1   <= i_valid;
            r_pr   <= w_pr;
            r_pg   <= w_pg;
            r_pb   <= w_pb;
            r_sb1  <= i_sb;
            r_v2   <= r_v1;
            r_gray <= w_sum[S_W-1:COEF_FRAC];
            r_sb2  <= r_sb1;
        end
    end

    assign o_valid = r_v2;
    assign o_gray  = r_gray;
    assign o_sb    = r_sb2;

endmodule

// File: rtl/frame_preproc_stream.sv
// Streaming RGB->gray preprocessor: rigid 3-stage pipeline with backpressure,
// optional 2:1 horizontal averaging and a sticky line-length error flag.
module frame_preproc_stream
    import preproc_pkg::*;
#(
    parameter int CH_W      = CH_W_DEF,
    parameter int COEF_R    = COEF_R_DEF,
    parameter int COEF_G    = COEF_G_DEF,
    parameter int COEF_B    = COEF_B_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int LINE_W    = LINE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    frame_preproc_stream_if.slave   i_pix,
    frame_preproc_stream_if.master  o_gray,
    input  logic                    i_cfg_decim,
    input  logic                    i_err_clr,
    output logic                    o_line_len_err
);

    localparam int CNT_W = $clog2(LINE_W + 1);

    logic              w_stall, w_en, w_accept, w_mode_in;
    logic              r_decim_mode;
    logic [2:0]        w_sb_in, w_sb2;
    logic              w_v2, w_mode2, w_sof2, w_eol2;
    logic [CH_W+2:0]   w_sum2;
    logic [CH_W-1:0]   w_sat;
    logic [CH_W:0]     w_avg_full;

    pair_state_t       r_state, w_state_nxt;
    logic [CH_W-1:0]   r_pair_buf, w_buf_nxt;
    logic              r_pair_sof, w_pair_sof_nxt;
    logic              w_fire, w_sof_out, w_eol_out;
    logic [CH_W-1:0]   w_dout;

    logic [CNT_W-1:0]  r_pix_cnt, w_cnt_cur;
    logic              w_len_bad;

    assign w_stall     = o_gray.valid && !o_gray.ready;
    assign w_en        = !w_stall;
    assign i_pix.ready = w_en;
    assign w_accept    = i_pix.valid && w_en;

    // The mode travels with each pixel so a mode switch at sof never
    // reinterprets pixels of the previous frame still in flight.
    assign w_mode_in = i_pix.sof ? i_cfg_decim : r_decim_mode;
    assign w_sb_in   = {w_mode_in, i_pix.sof, i_pix.eol};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decim_mode <= 1'b0;
        end else if (w_accept && i_pix.sof) begin
            r_decim_mode <= i_cfg_decim;
        end
    end

    rgb2gray_pipe #(
        .CH_W      (CH_W),
        .COEF_R    (COEF_R),
        .COEF_G    (COEF_G),
        .COEF_B    (COEF_B),
        .COEF_FRAC (COEF_FRAC),
        .SB_W      (3)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_valid (w_accept),
        .i_rgb   (i_pix.data[3*CH_W-1:0]),
        .i_sb    (w_sb_in),
        .o_valid (w_v2),
        .o_gray  (w_sum2),
        .o_sb    (w_sb2)
    );

    assign w_mode2    = w_sb2[2];
    assign w_sof2     = w_sb2[1];
    assign w_eol2     = w_sb2[0];
    assign w_sat      = (|w_sum2[CH_W+2:CH_W]) ? {CH_W{1'b1}} : w_sum2[CH_W-1:0];
    assign w_avg_full = {1'b0, r_pair_buf} + {1'b0, w_sat} + (CH_W+1)'(1);

    // S3: pairing FSM; a sof pixel always starts a fresh pair.
    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_pair_buf;
        w_pair_sof_nxt = r_pair_sof;
        w_fire         = 1'b0;
        w_dout         = w_sat;
        w_sof_out      = w_sof2;
        w_eol_out      = w_eol2;
        if (w_v2) begin
            if (!w_mode2) begin
                w_fire      = 1'b1;
                w_state_nxt = PAIR_IDLE;
            end else if (r_state == PAIR_HOLD && !w_sof2) begin
                w_fire      = 1'b1;
                w_dout      = w_avg_full[CH_W:1];
                w_sof_out   = r_pair_sof | w_sof2;
                w_state_nxt = PAIR_IDLE;
            end else if (w_eol2) begin
                w_fire      = 1'b1;
                w_state_nxt = PAIR_IDLE;
            end else begin
                w_buf_nxt      = w_sat;
                w_pair_sof_nxt = w_sof2;
                w_state_nxt    = PAIR_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PAIR_IDLE;
            r_pair_buf   <= '0;
            r_pair_sof   <= 1'b0;
            o_gray.valid <= 1'b0;
            o_gray.data  <= '0;
            o_gray.sof   <= 1'b0;
            o_gray.eol   <= 1'b0;
        end else if (w_en) begin
            r_state      <= w_state_nxt;
            r_pair_buf   <= w_buf_nxt;
            r_pair_sof   <= w_pair_sof_nxt;
            o_gray.valid <= w_fire;
            if (w_fire) begin
                o_gray.data <= w_dout;
                o_gray.sof  <= w_sof_out;
                o_gray.eol  <= w_eol_out;
            end
        end
    end

    // A sof beat counts as pixel 0 of its line regardless of the old count.
    assign w_cnt_cur = i_pix.sof ? '0 : r_pix_cnt;
    assign w_len_bad = w_accept && i_pix.eol && (w_cnt_cur != CNT_W'(LINE_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
        end else if (w_accept) begin
            if (i_pix.eol) begin
                r_pix_cnt <= '0;
            end else if (w_cnt_cur != CNT_W'(LINE_W)) begin
                r_pix_cnt <= w_cnt_cur + CNT_W'(1);
            end else begin
                r_pix_cnt <= w_cnt_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_line_len_err <= 1'b0;
        end else if (w_len_bad) begin
            o_line_len_err <= 1'b1;
        end else if (i_err_clr) begin
            o_line_len_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_preproc_stream.sv
// Scoreboard bench for frame_preproc_stream with a short line width so the
// length check, decimation corners, backpressure and reset can all be reached.
module tb_frame_preproc_stream;

    localparam int LW = 4;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfgDecim, errClr, lineLenErr;

    always #5 clk = ~clk;

    frame_preproc_stream_if #(.DATA_W(24)) inIf ();
    frame_preproc_stream_if #(.DATA_W(8))  outIf ();

    frame_preproc_stream #(.LINE_W(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pix          (inIf),
        .o_gray         (outIf),
        .i_cfg_decim    (cfgDecim),
        .i_err_clr      (errClr),
        .o_line_len_err (lineLenErr)
    );

    exp_t       expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         outCnt = 0;
    int         readyMode = 0;
    int         rIdx = 0;
    logic       monOn = 1'b0;
    logic       prevStall = 1'b0;
    logic [7:0] prevData;
    logic       prevSof, prevEol;

    int         mMode = 0;
    int         mPend = 0;
    int         mBuf = 0;
    logic       mPairSof = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, act, expv);
        end
    endtask

    function automatic int goldGray(input logic [23:0] rgb);
        int s;
        s = (32'(rgb[23:16]) * 77 + 32'(rgb[15:8]) * 150 + 32'(rgb[7:0]) * 29 + 128) >> 8;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic logic [23:0] gv(input logic [7:0] v);
        return {v, v, v};
    endfunction

    task automatic pushExp(input int d, input logic s, input logic e);
        exp_t x;
        x.data = 8'(d);
        x.sof  = s;
        x.eol  = e;
        expQ.push_back(x);
    endtask

    // Reference behaviour for one accepted beat.
    task automatic modelBeat(input logic [23:0] rgb, input logic sof, input logic eol, input logic cfg);
        int g;
        g = goldGray(rgb);
        if (sof) mMode = int'(cfg);
        if (mMode == 0) begin
            pushExp(g, sof, eol);
            mPend = 0;
        end else if (mPend != 0 && !sof) begin
            pushExp((mBuf + g + 1) / 2, mPairSof | sof, eol);
            mPend = 0;
        end else if (eol) begin
            pushExp(g, sof, eol);
            mPend = 0;
        end else begin
            mBuf     = g;
            mPairSof = sof;
            mPend    = 1;
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (readyMode == 0) begin
            outIf.ready = 1'b1;
        end else begin
            outIf.ready = ((rIdx % 4) == 0) || ((rIdx % 4) == 3);
            rIdx++;
        end
    end

    always @(negedge clk) begin
        if (monOn && rst_n) begin
            if (prevStall) begin
                checkOutput("stall_data_stable", 32'(outIf.data), 32'(prevData));
                checkOutput("stall_sof_stable", 32'(outIf.sof), 32'(prevSof));
                checkOutput("stall_eol_stable", 32'(outIf.eol), 32'(prevEol));
            end
            if (outIf.valid && !outIf.ready) begin
                checkOutput("stall_in_ready", 32'(inIf.ready), 32'd0);
                prevStall = 1'b1;
                prevData  = outIf.data;
                prevSof   = outIf.sof;
                prevEol   = outIf.eol;
            end else begin
                prevStall = 1'b0;
            end
            if (outIf.valid && outIf.ready) begin
                outCnt++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("out_data", 32'(outIf.data), 32'(e.data));
                    checkOutput("out_sof", 32'(outIf.sof), 32'(e.sof));
                    checkOutput("out_eol", 32'(outIf.eol), 32'(e.eol));
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 just after the accepting edge.
    task automatic applyStimulus(input logic [23:0] rgb, input logic sof, input logic eol,
                                 input logic cfg, output int accCyc);
        logic ok;
        ok = 1'b0;
        accCyc = -1;
        inIf.data  = rgb;
        inIf.sof   = sof;
        inIf.eol   = eol;
        cfgDecim   = cfg;
        inIf.valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inIf.ready) begin
                ok = 1'b1;
                accCyc = cyc;
                modelBeat(rgb, sof, eol, cfg);
            end
            @(posedge clk);
            if (ok) break;
        end
        #2;
        inIf.valid = 1'b0;
        inIf.sof   = 1'b0;
        inIf.eol   = 1'b0;
        if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
        end
        idle(2);
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    task automatic pulseClr();
        errClr = 1'b1;
        idle(1);
        errClr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, outAt, cntBefore;
        logic [23:0] rgb;

        inIf.valid = 1'b0;
        inIf.data  = '0;
        inIf.sof   = 1'b0;
        inIf.eol   = 1'b0;
        cfgDecim   = 1'b0;
        errClr     = 1'b0;
        outIf.ready = 1'b1;

        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(outIf.valid), 32'd0);
        checkOutput("rst_out_data", 32'(outIf.data), 32'd0);
        checkOutput("rst_out_sof", 32'(outIf.sof), 32'd0);
        checkOutput("rst_out_eol", 32'(outIf.eol), 32'd0);
        checkOutput("rst_line_len_err", 32'(lineLenErr), 32'd0);
        checkOutput("rst_in_ready", 32'(inIf.ready), 32'd1);
        monOn = 1'b1;
        idle(1);

        $display("[TB] single pixel latency");
        applyStimulus({8'd122, 8'd23, 8'd100}, 1'b1, 1'b1, 1'b0, acc);
        outAt = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (outIf.valid) begin
                outAt = cyc;
                break;
            end
        end
        checkOutput("latency_cycles", 32'(outAt - acc), 32'd3);
        waitDrain("drain_single");
        checkOutput("len_err_short_line", 32'(lineLenErr), 32'd1);
        pulseClr();
        checkOutput("len_err_cleared", 32'(lineLenErr), 32'd0);

        $display("[TB] decimation even line");
        applyStimulus(gv(8'd10), 1'b1, 1'b0, 1'b1, acc);
        applyStimulus(gv(8'd21), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(gv(8'd30), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(gv(8'd40), 1'b0, 1'b1, 1'b0, acc);
        waitDrain("drain_decim_even");
        checkOutput("len_ok_four_pixels", 32'(lineLenErr), 32'd0);

        $display("[TB] decimation odd line");
        applyStimulus(gv(8'd10), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(gv(8'd20), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(gv(8'd30), 1'b0, 1'b1, 1'b0, acc);
        checkOutput("len_err_after_eol", 32'(lineLenErr), 32'd1);
        waitDrain("drain_decim_odd");
        pulseClr();
        checkOutput("len_err_cleared2", 32'(lineLenErr), 32'd0);

        $display("[TB] set beats clear");
        errClr = 1'b1;
        applyStimulus(gv(8'd90), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(gv(8'd91), 1'b0, 1'b1, 1'b0, acc);
        errClr = 1'b0;
        checkOutput("len_err_set_wins", 32'(lineLenErr), 32'd1);
        waitDrain("drain_set_wins");

        $display("[TB] sof discards pending pixel");
        applyStimulus(gv(8'd50), 1'b1, 1'b0, 1'b1, acc);
        applyStimulus(gv(8'd100), 1'b1, 1'b0, 1'b1, acc);
        applyStimulus(gv(8'd61), 1'b0, 1'b1, 1'b1, acc);
        waitDrain("drain_sof_pending");
        pulseClr();

        $display("[TB] backpressure stream");
        cntBefore = outCnt;
        readyMode = 1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      rgb = 24'hFFFFFF;
            else if (i == 1) rgb = 24'h000000;
            else             rgb = 24'($urandom);
            applyStimulus(rgb, (i == 0), ((i % 4) == 3), (i != 0), acc);
        end
        waitDrain("drain_stream");
        readyMode = 0;
        idle(2);
        checkOutput("stream_count", 32'(outCnt - cntBefore), 32'd16);
        checkOutput("len_ok_stream", 32'(lineLenErr), 32'd0);

        $display("[TB] reset with pixels in flight");
        applyStimulus(gv(8'd70), 1'b1, 1'b0, 1'b1, acc);
        applyStimulus(gv(8'd80), 1'b0, 1'b0, 1'b0, acc);
        rst_n = 1'b0;
        expQ.delete();
        mMode = 0;
        mPend = 0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("post_reset_no_valid", 32'(outIf.valid), 32'd0);
        end
        idle(1);
        applyStimulus(gv(8'd5), 1'b1, 1'b0, 1'b0, acc);
        applyStimulus({8'd200, 8'd100, 8'd50}, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus({8'd0, 8'd255, 8'd0}, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus({8'd1, 8'd2, 8'd3}, 1'b0, 1'b1, 1'b0, acc);
        waitDrain("drain_after_reset");
        checkOutput("len_ok_after_reset", 32'(lineLenErr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
